preg_arb: RTL and testbench

PREG_ARB -- requirements
Module: preg_arb

---
 rtl/preg_arb_pkg.sv | 16 +
 rtl/preg_arb_prio.sv | 44 ++++
 rtl/preg_arb.sv | 95 +++++++++
 tb/tb_preg_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/preg_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package preg_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int CTRL_WE     = 0;
  localparam int CTRL_RT_SEL = 1;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_STARVE_LIMIT = 3;

endpackage

// File: rtl/preg_arb_prio.sv
// ALU-over-IO priority with an anti-starvation counter that forces an IO win
// after STARVE_LIMIT consecutive denied IO cycles.
module preg_arb_prio
  import preg_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic alu_req_i,
  input  logic io_req_i,
  output logic alu_gnt_o,
  output logic io_gnt_o
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          io_wins;
  logic          io_denied;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // The counter only runs while IO keeps asking and keeps losing; anything else clears it.
  always_comb begin
    io_wins   = io_req_i && (!alu_req_i || (starve_q == LIMIT));
    alu_gnt_o = run_i && alu_req_i && !io_wins;
    io_gnt_o  = run_i && io_wins;
    io_denied = run_i && io_req_i && !io_wins;
    starve_d  = '0;
    if (io_denied) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CW'(1);
    end
  end

endmodule

// File: rtl/preg_arb.sv
// Register-file write port arbiter: clears every register after reset, then
// arbitrates ALU and IO writebacks onto the single write port.
module preg_arb
  import preg_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_req,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_wdata,
  output logic                  alu_gnt,
  input  logic                  io_req,
  input  logic [ADDR_WIDTH-1:0] io_rd,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  io_gnt,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rt_sel,
  output logic [ADDR_WIDTH-1:0] Rd,
  output logic [DATA_WIDTH-1:0] Wdata,
  output logic [1:0]            ctrl,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  run;

  assign run       = (state_q == RUN) && !reset;
  assign init_done = run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep counter wraps to zero on leaving INIT, so it is clean for the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == LAST_ADDR) begin
        state_d = RUN;
      end
    end
  end

  preg_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk       (clk),
    .reset     (reset),
    .run_i     (run),
    .alu_req_i (alu_req),
    .io_req_i  (io_req),
    .alu_gnt_o (alu_gnt),
    .io_gnt_o  (io_gnt)
  );

  // Writes to register 0 are granted but never enabled, keeping it hard-wired to zero.
  always_comb begin
    Rd    = '0;
    Wdata = '0;
    ctrl  = '0;
    if (!run) begin
      Rd             = reset ? '0 : cnt_q;
      ctrl[CTRL_WE]  = 1'b1;
    end else begin
      ctrl[CTRL_RT_SEL] = rt_sel;
      if (alu_gnt) begin
        Rd            = alu_rd;
        Wdata         = alu_wdata;
        ctrl[CTRL_WE] = (alu_rd != '0);
      end else if (io_gnt) begin
        Rd            = io_rd;
        Wdata         = io_wdata;
        ctrl[CTRL_WE] = (io_rd != '0);
      end else begin
        Rd = rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_preg_arb.sv
// Self-checking bench for preg_arb with a register file model driven by the DUT
// write port and a behavioural reference model of sweep and arbitration.
module tb_preg_arb;
  import preg_arb_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int SL   = 3;
  localparam int NREG = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_req, io_req, rt_sel;
  logic [AW-1:0] alu_rd, io_rd, rd_addr;
  logic [DW-1:0] alu_wdata, io_wdata;
  logic          alu_gnt, io_gnt, init_done;
  logic [AW-1:0] Rd;
  logic [DW-1:0] Wdata;
  logic [1:0]    ctrl;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] dutRegs   [NREG];
  logic [DW-1:0] modelRegs [NREG];
  bit            seeded      = 1'b0;
  bit            modelInInit = 1'b1;
  int            modelAddr   = 0;
  int            modelStarve = 0;
  bit            lastAluGnt  = 1'b0;
  bit            checkEn     = 1'b0;

  always #5 clk = ~clk;

  preg_arb #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_req   (alu_req),
    .alu_rd    (alu_rd),
    .alu_wdata (alu_wdata),
    .alu_gnt   (alu_gnt),
    .io_req    (io_req),
    .io_rd     (io_rd),
    .io_wdata  (io_wdata),
    .io_gnt    (io_gnt),
    .rd_addr   (rd_addr),
    .rt_sel    (rt_sel),
    .Rd        (Rd),
    .Wdata     (Wdata),
    .ctrl      (ctrl),
    .init_done (init_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected outputs straight from the rules: sweep address while clearing,
  // otherwise IO wins only when ALU is idle or IO has waited SL cycles.
  function automatic void predict(output logic eAlu, output logic eIo, output logic [AW-1:0] eRd,
                                  output logic [DW-1:0] eWd, output logic [1:0] eCtrl, output logic eDone);
    eAlu  = 1'b0;
    eIo   = 1'b0;
    eWd   = '0;
    eDone = 1'b0;
    if (reset || modelInInit) begin
      eRd   = reset ? '0 : AW'(modelAddr);
      eCtrl = 2'b01;
    end else begin
      eDone = 1'b1;
      eCtrl = {rt_sel, 1'b0};
      eIo   = io_req && (!alu_req || modelStarve >= SL);
      eAlu  = alu_req && !eIo;
      if (eAlu) begin
        eRd = alu_rd; eWd = alu_wdata; eCtrl[0] = (alu_rd != '0);
      end else if (eIo) begin
        eRd = io_rd; eWd = io_wdata; eCtrl[0] = (io_rd != '0);
      end else begin
        eRd = rd_addr;
      end
    end
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic eAlu, eIo, eDone;
    logic [AW-1:0] eRd;
    logic [DW-1:0] eWd;
    logic [1:0] eCtrl;
    if (checkEn) begin
      predict(eAlu, eIo, eRd, eWd, eCtrl, eDone);
      checkOutput("model alu_gnt", 32'(alu_gnt), 32'(eAlu));
      checkOutput("model io_gnt", 32'(io_gnt), 32'(eIo));
      checkOutput("model Rd", 32'(Rd), 32'(eRd));
      checkOutput("model Wdata", 32'(Wdata), 32'(eWd));
      checkOutput("model ctrl", 32'(ctrl), 32'(eCtrl));
      checkOutput("model init_done", 32'(init_done), 32'(eDone));
    end
  end

  // Register file fed by the DUT write port, plus the model state update.
  always @(posedge clk) begin
    logic eAlu, eIo, eDone;
    logic [AW-1:0] eRd;
    logic [DW-1:0] eWd;
    logic [1:0] eCtrl;
    logic [DW-1:0] v;
    if (!seeded) begin
      for (int i = 0; i < NREG; i++) begin
        v = DW'($urandom_range(1, 255));
        dutRegs[i]   <= v;
        modelRegs[i] <= v;
      end
      seeded <= 1'b1;
    end
    if (ctrl[0] === 1'b1) dutRegs[Rd] <= Wdata;
    predict(eAlu, eIo, eRd, eWd, eCtrl, eDone);
    if (reset) begin
      modelInInit  <= 1'b1;
      modelAddr    <= 0;
      modelStarve  <= 0;
      modelRegs[0] <= '0;
    end else if (modelInInit) begin
      modelRegs[modelAddr] <= '0;
      modelStarve <= 0;
      if (modelAddr == NREG - 1) begin
        modelInInit <= 1'b0;
        modelAddr   <= 0;
      end else begin
        modelAddr <= modelAddr + 1;
      end
    end else begin
      if (eAlu && alu_rd != '0) modelRegs[alu_rd] <= alu_wdata;
      if (eIo && io_rd != '0) modelRegs[io_rd] <= io_wdata;
      modelStarve <= (io_req && !eIo) ? ((modelStarve < SL) ? modelStarve + 1 : SL) : 0;
    end
    lastAluGnt <= eAlu;
  end

  task automatic applyStimulus(input logic aReq, input logic [AW-1:0] aRd, input logic [DW-1:0] aData,
                               input logic iReq, input logic [AW-1:0] iRd, input logic [DW-1:0] iData,
                               input logic [AW-1:0] rAddr, input logic rt);
    alu_req = aReq; alu_rd = aRd; alu_wdata = aData;
    io_req  = iReq; io_rd  = iRd; io_wdata  = iData;
    rd_addr = rAddr; rt_sel = rt;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of sweep cycle 1; ends after checking cycle 33.
  task automatic sweepCheck();
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k <= 32) begin
        checkOutput("sweep Rd", 32'(Rd), 32'(k - 1));
        checkOutput("sweep ctrl", 32'(ctrl), 32'(2'b01));
      end
      checkOutput("sweep init_done", 32'(init_done), 32'(k == 33));
      if (k < 33) nextCycle();
    end
  endtask

  bit ioPattern [6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  bit ioExpect  [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    nextCycle();
    checkEn = 1'b1;
    nextCycle();
    reset = 1'b0;
    sweepCheck();
    for (int i = 0; i < NREG; i++) checkOutput("reg cleared", 32'(dutRegs[i]), 32'h0);
    nextCycle();

    // Idle read passthrough.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, AW'(7), 1'b1);
    @(negedge clk);
    checkOutput("idle Rd", 32'(Rd), 32'd7);
    checkOutput("idle ctrl", 32'(ctrl), 32'(2'b10));
    nextCycle();

    // Both held: ALU three times, then the starved IO.
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b1, AW'(5), 8'hA5, 1'b1, AW'(6), 8'h3C, '0, 1'b0);
      @(negedge clk);
      checkOutput("contend alu_gnt", 32'(alu_gnt), 32'(c <= 3));
      checkOutput("contend io_gnt", 32'(io_gnt), 32'(c == 4));
      nextCycle();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("reg5", 32'(dutRegs[5]), 32'hA5);
    checkOutput("reg6", 32'(dutRegs[6]), 32'h3C);
    nextCycle();

    // Write to register 0 is granted but not enabled.
    applyStimulus(1'b0, '0, '0, 1'b1, '0, 8'hFF, '0, 1'b0);
    @(negedge clk);
    checkOutput("r0 io_gnt", 32'(io_gnt), 32'd1);
    checkOutput("r0 we", 32'(ctrl[0]), 32'd0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("reg0", 32'(dutRegs[0]), 32'h0);
    nextCycle();

    // A dropped IO request restarts the starvation count.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, AW'(9), 8'h11, ioPattern[c], AW'(10), 8'h22, '0, 1'b0);
      @(negedge clk);
      checkOutput("toggle io_gnt", 32'(io_gnt), 32'(ioExpect[c]));
      nextCycle();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    nextCycle();

    // Reset in the middle of the sweep restarts it at address 0.
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) nextCycle();
    @(negedge clk);
    checkOutput("pre-reset Rd", 32'(Rd), 32'd12);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    sweepCheck();
    nextCycle();

    // Randomized traffic with requests held until granted.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      if (!alu_req || lastAluGnt) begin
        alu_req   = ($urandom_range(0, 9) < 6);
        alu_rd    = AW'($urandom);
        alu_wdata = DW'($urandom);
      end
      if (!io_req || io_gnt) begin
        io_req   = ($urandom_range(0, 9) < 5);
        io_rd    = AW'($urandom);
        io_wdata = DW'($urandom);
      end
      rd_addr = AW'($urandom);
      rt_sel  = 1'($urandom);
      nextCycle();
    end
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    for (int c = 0; c < 40; c++) nextCycle();
    @(negedge clk);
    for (int i = 0; i < NREG; i++) checkOutput("final reg", 32'(dutRegs[i]), 32'(modelRegs[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
